// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Unbuffered UART transmitter for one DZ11 serial line. Accepts a
//            character on a one-cycle load, sends it LSB first framed by a
//            start bit, optional parity and one or two stop bits. Each bit
//            lasts 16 brgCLKEN pulses.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous reset, active low
//            clr      - synchronous clear, active high (same effect as rst)
//            brgCLKEN - baud enable, 16 pulses per bit time
//            length   - character length code (5..8 bits)
//            parity   - parity mode code (none / even / odd)
//            stop     - stop bit code (0: one, 1: two)
//            load     - one-cycle request to transmit data (honoured in idle)
//            data     - character, bits above the length are ignored
//            brk      - line break request
//            txd      - registered serial output, idle high
//            empty    - high while idle and able to accept load
//            intr     - one-clock pulse at end of frame
// Options  : DZUART_TX_BREAK_EN - when defined, brk forces txd low
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       brgCLKEN,
  input  logic [1:0] length,
  input  logic [1:0] parity,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       brk,
  output logic       txd,
  output logic       empty,
  output logic       intr
);

  // Encodings shared with dzuart.vh
  localparam logic [1:0] c_LEN_5    = 2'b00;
  localparam logic [1:0] c_LEN_6    = 2'b01;
  localparam logic [1:0] c_LEN_7    = 2'b10;
  localparam logic [1:0] c_PAR_EVEN = 2'b01;
  localparam logic [1:0] c_PAR_ODD  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_BIT0   = 4'd2,
    S_BIT1   = 4'd3,
    S_BIT2   = 4'd4,
    S_BIT3   = 4'd5,
    S_BIT4   = 4'd6,
    S_BIT5   = 4'd7,
    S_BIT6   = 4'd8,
    S_BIT7   = 4'd9,
    S_PARITY = 4'd10,
    S_STOP1  = 4'd11,
    S_STOP2  = 4'd12,
    S_DONE   = 4'd13
  } state_t;

  state_t     state_q, state_d, after_data;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] load_mask, load_bits;
  logic [1:0] len_q, len_d;
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic       two_stop_q, two_stop_d;
  logic       line_q, line_d;   // frame waveform before any break override
  logic       txd_q, txd_d;
  logic       intr_q, intr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    line_d     = line_q;
    intr_d     = 1'b0;

    // Keep only the low 'length' bits; both the shifter and parity see them.
    load_mask  = 8'hFF >> (2'd3 - length);
    load_bits  = data & load_mask;
    after_data = par_en_q ? S_PARITY : S_STOP1;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d    = S_START;
          cnt_d      = 4'd15;
          shift_d    = load_bits;
          len_d      = length;
          par_en_d   = (parity == c_PAR_EVEN) || (parity == c_PAR_ODD);
          par_bit_d  = (^load_bits) ^ (parity == c_PAR_ODD);
          two_stop_d = stop;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (brgCLKEN) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            cnt_d = 4'd15;
            case (state_q)
              S_START:  state_d = S_BIT0;
              S_BIT0:   state_d = S_BIT1;
              S_BIT1:   state_d = S_BIT2;
              S_BIT2:   state_d = S_BIT3;
              S_BIT3:   state_d = S_BIT4;
              S_BIT4:   state_d = (len_q == c_LEN_5) ? after_data : S_BIT5;
              S_BIT5:   state_d = (len_q == c_LEN_6) ? after_data : S_BIT6;
              S_BIT6:   state_d = (len_q == c_LEN_7) ? after_data : S_BIT7;
              S_BIT7:   state_d = after_data;
              S_PARITY: state_d = S_STOP1;
              S_STOP1:  state_d = two_stop_q ? S_STOP2 : S_DONE;
              default:  state_d = S_DONE;
            endcase
          end
        end
      end
    endcase

    // txd is registered, so the line level is chosen for the state being
    // entered; data bits pop off the bottom of the shifter as they go out.
    if (state_d != state_q) begin
      case (state_d)
        S_START: line_d = 1'b0;
        S_BIT0, S_BIT1, S_BIT2, S_BIT3,
        S_BIT4, S_BIT5, S_BIT6, S_BIT7: begin
          line_d  = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
        S_PARITY: line_d = par_bit_q;
        default:  line_d = 1'b1;
      endcase
    end

    intr_d = (state_d == S_DONE);

`ifdef DZUART_TX_BREAK_EN
    // Break overrides the line only; the frame keeps running underneath.
    txd_d = brk ? 1'b0 : line_d;
`else
    // brk has no effect in this build.
    txd_d = line_d | (brk & 1'b0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd15;
      shift_q    <= 8'd0;
      len_q      <= 2'd0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      line_q     <= 1'b1;
      txd_q      <= 1'b1;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      line_q     <= line_d;
      txd_q      <= txd_d;
      intr_q     <= intr_d;
    end
  end

  assign txd   = txd_q;
  assign empty = (state_q == S_IDLE);
  assign intr  = intr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx. Each accepted load queues the
//            expected frame (bit list built from the framing rules); a
//            monitor pops it when empty falls and follows the line by
//            counting brgCLKEN pulses, 16 per bit.
// Options  : DZUART_TX_BREAK_EN - expects brk to force txd low
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
`ifdef DZUART_TX_BREAK_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       brgCLKEN = 1'b0;
  logic [1:0] length = 2'd0;
  logic [1:0] parity = 2'd0;
  logic       stop = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data = 8'd0;
  logic       brk = 1'b0;
  logic       txd, empty, intr;

  uart_tx dut (
    .clk(clk), .rst(rst), .clr(clr), .brgCLKEN(brgCLKEN),
    .length(length), .parity(parity), .stop(stop), .load(load),
    .data(data), .brk(brk), .txd(txd), .empty(empty), .intr(intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;   // bits[i] is the line level during bit time i
    int          nb;     // number of bit times in the frame
  } frame_t;

  int          checks = 0;
  int          failures = 0;
  frame_t      exp_q[$];
  frame_t      cur;
  int unsigned div = 1;          // brgCLKEN every div clks; 0 = random
  int unsigned brg_ph = 0;
  int unsigned pulses_total = 0;
  int unsigned base = 0;
  int unsigned mon_k = 0;
  logic        brk_seen = 1'b0;
  logic        brk_eff;
  bit          mon_en = 1'b0;
  bit          abort_req = 1'b0;
  int          mstate = 0;       // 0 idle, 1 in frame, 2 after done, 3 resync

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  // Reference frame built directly from the framing rules.
  function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] l,
                                        input logic [1:0] p, input logic s);
    frame_t f;
    int     len;
    int     n;
    logic   ones;
    len    = 5 + int'(l);
    f.bits = '1;
    f.bits[0] = 1'b0;
    ones   = 1'b0;
    for (int i = 0; i < len; i++) begin
      f.bits[1 + i] = d[i];
      ones ^= d[i];
    end
    n = 1 + len;
    if (p == PAR_EVEN || p == PAR_ODD) begin
      f.bits[n] = (p == PAR_ODD) ? ~ones : ones;
      n++;
    end
    n += s ? 2 : 1;
    f.nb = n;
    return f;
  endfunction

  always @(posedge clk) begin
    if (brgCLKEN) pulses_total <= pulses_total + 1;
    brk_seen <= brk;
  end

  // Baud enable generator
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (div == 0) begin
        brgCLKEN = ($urandom_range(0, 2) == 0);
      end else begin
        brgCLKEN = (brg_ph == 0);
        brg_ph   = (brg_ph + 1 >= div) ? 0 : brg_ph + 1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      brk_eff = brk_seen & BREAK_EN;
      if (abort_req) begin
        abort_req = 1'b0;
        chk("abort_txd", txd, 1);
        chk("abort_empty", empty, 1);
        chk("abort_intr", intr, 0);
        mstate = 0;
      end else begin
        if (mstate == 3 && empty === 1'b1) begin
          mstate = 0;
        end else if (mstate == 0) begin
          if (empty === 1'b0) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_frame: got frame start expected none at %0t", $time);
              mstate = 3;
            end else begin
              cur    = exp_q.pop_front();
              base   = pulses_total;
              mstate = 1;
            end
          end else begin
            chk("idle_txd", txd, brk_eff ? 0 : 1);
            chk("idle_intr", intr, 0);
          end
        end else if (mstate == 2) begin
          chk("post_intr", intr, 0);
          chk("post_empty", empty, 1);
          chk("post_txd", txd, brk_eff ? 0 : 1);
          mstate = 0;
        end

        if (mstate == 1) begin
          mon_k = pulses_total - base;
          if (mon_k < 16 * cur.nb) begin
            chk("frame_txd", txd, brk_eff ? 0 : cur.bits[mon_k / 16]);
            chk("frame_empty", empty, 0);
            chk("frame_intr", intr, 0);
          end else begin
            chk("done_len", mon_k, 16 * cur.nb);
            chk("done_intr", intr, 1);
            chk("done_txd", txd, brk_eff ? 0 : 1);
            chk("done_empty", empty, 0);
            mstate = 2;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] l,
                      input logic [1:0] p, input logic s);
    int t;
    t = 0;
    while (empty !== 1'b1 && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) fail_timeout("wait_empty");
    data   = d;
    length = l;
    parity = p;
    stop   = s;
    load   = 1'b1;
    exp_q.push_back(make_frame(d, l, p, s));
    tick();
    load   = 1'b0;
    // Configuration must be frozen at load; scramble it for the rest of the frame.
    data   = 8'($urandom);
    length = 2'($urandom);
    parity = 2'($urandom);
    stop   = 1'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mstate != 0) && t < 20000) begin
      tick();
      t++;
    end
    if (t >= 20000) fail_timeout("frame_done");
    repeat (3) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, baud enable every clock
    div = 1;
    rst = 1'b0;
    tick();
    tick();
    chk("reset_txd", txd, 1);
    chk("reset_empty", empty, 1);
    chk("reset_intr", intr, 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (100) tick();

    // 8N1 0xA5, enable every 4th clock
    div = 4;
    send(8'hA5, 2'd3, PAR_NONE, 1'b0);
    wait_done();

    // 7E1 0xC3 then 5O2 0xFF back to back
    div = 1;
    send(8'hC3, 2'd2, PAR_EVEN, 1'b0);
    send(8'hFF, 2'd0, PAR_ODD, 1'b1);
    wait_done();

    // Load during BIT3 of 0x00 must be ignored
    div = 2;
    send(8'h00, 2'd3, PAR_NONE, 1'b0);
    repeat (16 * 4 * 2 + 10) tick();
    data = 8'h55;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_done();

    // clr together with load during BIT2: frame aborted, load discarded
    div = 1;
    send(8'($urandom), 2'd3, PAR_NONE, 1'b0);
    repeat (52) tick();
    clr       = 1'b1;
    load      = 1'b1;
    data      = 8'($urandom);
    abort_req = 1'b1;
    tick();
    clr  = 1'b0;
    load = 1'b0;
    repeat (20) tick();

    // Break held across a frame of 0xFF
    div = 1;
    send(8'hFF, 2'd3, PAR_NONE, 1'b0);
    brk = 1'b1;
    repeat (300) tick();
    brk = 1'b0;
    wait_done();
    repeat (5) tick();

    // Random frames, random baud pattern, many back to back
    for (int i = 0; i < 25; i++) begin
      div = $urandom_range(0, 3);
      send(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 30)) tick();
    end
    wait_done();

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Generic unbuffered UART transmitter for the DZ11 serial line path: accepts one character from the line logic, serialises it LSB first at 16 `brgCLKEN` pulses per bit, and frames it with start, optional parity, and 1 or 2 stop bits. It is the transmit side of each DZ11 line and shares the per-line baud rate generator enable with the receiver. Character length, parity and stop-bit encodings are the `dzuart.vh` macros: `UARTLEN_5..8`, `UARTPAR_NONE/EVEN/ODD`, `UARTSTOP_1/2`. Any buffering is layered above this block.

## Interface
- No parameters.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset: one clock, synchronous, active-low. Asserted (0) on a rising edge of `clk` resets the block.
- clr  input  1  synchronous clear, active-high; same effect as reset.
- brgCLKEN  input  1  baud clock enable, 16 pulses per bit time.
- length  input  2  character length (`UARTLEN_5..8`).
- parity  input  2  parity mode (`UARTPAR_NONE/EVEN/ODD`).
- stop  input  1  stop bits (`UARTSTOP_1/2`).
- load  input  1  one-cycle request to transmit `data`.
- data  input  8  character; bits above `length` are ignored.
- brk  input  1  line break request (see Configuration).
- txd  output  1  serial data, registered, idle high.
- empty  output  1  high when idle and able to accept `load`.
- intr  output  1  one-clock pulse at end of frame.

## Operation
- States: IDLE, START, BIT0–BIT7, PARITY, STOP1, STOP2, DONE.
- Bit timer: 4-bit down-counter. Each bit lasts exactly 16 `brgCLKEN` pulses.
- IDLE:
  - `txd`=1 and `empty`=1.
  - `load`=1 latches `data`, `length`, `parity` and `stop` into holding registers and moves to START.
  - Configuration inputs are sampled only at `load`. Changes during a frame do not affect it.
- START: `txd`=0 for one bit, then BIT0.
- BITn: `txd`=shift[0], then the register shifts right.
  - BIT4, BIT5 and BIT6 exit to PARITY or STOP1 when the latched length is 5, 6 or 7.
  - BIT7 always exits to PARITY or STOP1.
- PARITY (entered only for EVEN/ODD):
  - EVEN: `txd` = XOR of the transmitted data bits, so the total count of ones is even.
  - ODD: `txd` = the complement of that XOR.
- STOP1: `txd`=1, then STOP2 if 2 stop bits are selected, else DONE.
- STOP2: `txd`=1, then DONE.
- DONE: lasts one clk. `intr`=1, `txd`=1, then IDLE.
- `load` is ignored in every state except IDLE. No overrun flag is raised.
- Parity is computed only over the masked, length-limited bits.

## Timing
- Reset / clr values: state=IDLE, `txd`=1, `empty`=1, `intr`=0, counter=15, shift register=0.
- Precedence: `rst` over `clr` over `load`, all in the same cycle.
- `clr` or `rst` in mid-frame:
  - takes effect on the next clock edge;
  - `txd` returns to 1;
  - no `intr` is generated.
- `load` sampled in IDLE at edge N:
  - `txd`=0 and `empty`=0 from edge N+1;
  - `empty` stays 0 until the clock after DONE.
- Start-bit timing does not align to `brgCLKEN`. The start bit lasts from edge N+1 through the 16th subsequent `brgCLKEN` pulse.
- Every later bit changes on the clock after its predecessor's 16th `brgCLKEN` pulse.
- Frame length in `brgCLKEN` pulses is 16×(1+len+P+S), where P is 1 when parity is enabled and S is the number of stop bits:
  - 5N1 = 112;
  - 8E2 = 192.
- DONE follows the last stop bit's 16th pulse by one clk.
- IDLE follows DONE by one clk. A `load` at that IDLE cycle produces back-to-back frames.
- `brgCLKEN` held low freezes the state machine and `txd` indefinitely.

## Configuration
- Macro: `DZUART_TX_BREAK_EN`.
- Defined:
  - while `brk`=1, `txd` is forced to 0 on the next clk;
  - the state machine keeps running, so the current character is sent corrupted;
  - `empty` and `intr` behave normally;
  - `txd` resumes normal output the clk after `brk` falls.
- Undefined:
  - `brk` is present but ignored;
  - `txd` depends only on the state machine.

## Test plan
- Reset with `rst`=0 for 2 clks, `brgCLKEN` every clk → `txd`=1, `empty`=1, `intr`=0; stays so for 100 clks with no `load`.
- 8N1, `data`=8'hA5, `brgCLKEN` every 4th clk → `txd` shows 0,1,0,1,0,0,1,0,1,1, each bit 16 `brgCLKEN` pulses long; single `intr` pulse; `empty` returns 1.
- 7E1 with 8'hC3, then 5O2 with 8'hFF → 7E1: bits 1,1,0,0,0,0,1 then parity 1; 5O2: bits 1,1,1,1,1 then parity 0, and the stop phase lasts 32 pulses.
- `load` of 8'h55 during BIT3 of 8'h00 → ignored; only 8'h00 is sent and exactly one `intr` is pulsed.
- `clr`=1 during BIT2 together with `load` → `txd`=1 and `empty`=1 next clk; no `intr`; the `load` is discarded.
- With `DZUART_TX_BREAK_EN`, `brk`=1 for 300 clks over a frame of 8'hFF → `txd`=0 throughout the break; `intr` still pulses at the frame's normal end. Without the macro, `txd` matches the plain 8'hFF frame.
